load_use_hazard_unit: RTL and testbench

Pipeline interlock that acts on hazard detections. It inserts a single-cycle bubble on load-use dependencies and freezes the pipeline while data memory is busy. It also produces the registered operand-forwarding selects consumed by the EX-stage operand muxes. It sits beside the ID/EX pipeline register and drives the PC, IF/ID and ID/EX write/flush controls.

---
 rtl/load_use_hazard_unit.sv | 132 +++++++++++++
 tb/tb_load_use_hazard_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/load_use_hazard_unit.sv
// Load-use interlock and memory-busy freeze with registered EX operand-forwarding selects.
// Define LOAD_USE_PERF_CNT_EN to add the saturating STALL_COUNT port.
module load_use_hazard_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [REG_ADDR_W-1:0] RS1_ID,
   input  logic [REG_ADDR_W-1:0] RS2_ID,
   input  logic                  USE_RS1_ID,
   input  logic                  USE_RS2_ID,
   input  logic [REG_ADDR_W-1:0] DEST_ALU,
   input  logic                  REG_WRITE_ALU,
   input  logic                  MEM_READ_ALU,
   input  logic [REG_ADDR_W-1:0] DEST_MEM,
   input  logic                  REG_WRITE_MEM,
   input  logic                  MEM_BUSY,
   input  logic                  BRANCH_TAKEN,
   output logic                  PC_WRITE_EN,
   output logic                  IF_ID_WRITE_EN,
   output logic                  ID_EX_BUBBLE,
   output logic                  PIPE_HOLD,
   output logic [1:0]            FWD_RS1_SEL,
   output logic [1:0]            FWD_RS2_SEL
`ifdef LOAD_USE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]      STALL_COUNT
`endif
);

   typedef enum logic [1:0] {
      RUN        = 2'b00,
      LOAD_STALL = 2'b01,
      MEM_HOLD   = 2'b10
   } state_t;

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_EX  = 2'b01;
   localparam logic [1:0] SEL_MEM = 2'b10;

   state_t     state;
   state_t     state_nxt;
   logic       hazard;
   logic       state_illegal;
   logic [1:0] fwd_rs1_nxt;
   logic [1:0] fwd_rs2_nxt;

   // A load in EX cannot forward; x0 is hard-wired and never forwarded.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_ADDR_W-1:0] rs,
      input logic [REG_ADDR_W-1:0] dest_alu,
      input logic                  wr_alu,
      input logic                  rd_alu,
      input logic [REG_ADDR_W-1:0] dest_mem,
      input logic                  wr_mem
   );
      if (wr_alu && dest_alu != '0 && dest_alu == rs && !rd_alu)
         return SEL_EX;
      else if (wr_mem && dest_mem != '0 && dest_mem == rs)
         return SEL_MEM;
      else
         return SEL_RF;
   endfunction

   assign hazard = MEM_READ_ALU && REG_WRITE_ALU && (DEST_ALU != '0) &&
                   ((USE_RS1_ID && DEST_ALU == RS1_ID) ||
                    (USE_RS2_ID && DEST_ALU == RS2_ID));

   // The unused encoding 2'b11 is recovered through a bubble back to RUN.
   assign state_illegal = !(state inside {RUN, LOAD_STALL, MEM_HOLD});

   // NOTE: every output of this block gets a default first, so no path leaves a latch.
   always_comb begin
      PC_WRITE_EN    = 1'b1;
      IF_ID_WRITE_EN = 1'b1;
      ID_EX_BUBBLE   = 1'b0;
      PIPE_HOLD      = 1'b0;
      state_nxt      = RUN;
      fwd_rs1_nxt    = fwd_sel(RS1_ID, DEST_ALU, REG_WRITE_ALU, MEM_READ_ALU, DEST_MEM, REG_WRITE_MEM);
      fwd_rs2_nxt    = fwd_sel(RS2_ID, DEST_ALU, REG_WRITE_ALU, MEM_READ_ALU, DEST_MEM, REG_WRITE_MEM);
      if (!RESET || state_illegal) begin
         PC_WRITE_EN    = 1'b0;
         IF_ID_WRITE_EN = 1'b0;
         ID_EX_BUBBLE   = 1'b1;
         fwd_rs1_nxt    = SEL_RF;
         fwd_rs2_nxt    = SEL_RF;
      end else if (MEM_BUSY) begin
         PIPE_HOLD      = 1'b1;
         PC_WRITE_EN    = 1'b0;
         IF_ID_WRITE_EN = 1'b0;
         state_nxt      = MEM_HOLD;
         fwd_rs1_nxt    = FWD_RS1_SEL;
         fwd_rs2_nxt    = FWD_RS2_SEL;
      end else if (BRANCH_TAKEN) begin
         ID_EX_BUBBLE   = 1'b1;
         fwd_rs1_nxt    = SEL_RF;
         fwd_rs2_nxt    = SEL_RF;
      end else if (hazard) begin
         PC_WRITE_EN    = 1'b0;
         IF_ID_WRITE_EN = 1'b0;
         ID_EX_BUBBLE   = 1'b1;
         state_nxt      = LOAD_STALL;
         fwd_rs1_nxt    = SEL_RF;
         fwd_rs2_nxt    = SEL_RF;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state       <= RUN;
         FWD_RS1_SEL <= SEL_RF;
         FWD_RS2_SEL <= SEL_RF;
      end else begin
         state       <= state_nxt;
         FWD_RS1_SEL <= fwd_rs1_nxt;
         FWD_RS2_SEL <= fwd_rs2_nxt;
      end
   end

`ifdef LOAD_USE_PERF_CNT_EN
   // Only the load-use bubble counts; branch bubbles and memory holds do not.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         STALL_COUNT <= '0;
      else if (state_nxt == LOAD_STALL && STALL_COUNT != '1)
         STALL_COUNT <= STALL_COUNT + 1'b1;
   end
`endif

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Directed bench for load_use_hazard_unit; STALL_COUNT checks follow LOAD_USE_PERF_CNT_EN.
module tb_load_use_hazard_unit;

   localparam int CNT_W = 3;
   localparam logic [1:0] ST_RUN        = 2'd0;
   localparam logic [1:0] ST_LOAD_STALL = 2'd1;
   localparam logic [1:0] ST_MEM_HOLD   = 2'd2;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [4:0] RS1_ID, RS2_ID, DEST_ALU, DEST_MEM;
   logic       USE_RS1_ID, USE_RS2_ID, REG_WRITE_ALU, MEM_READ_ALU, REG_WRITE_MEM;
   logic       MEM_BUSY, BRANCH_TAKEN;
   logic       PC_WRITE_EN, IF_ID_WRITE_EN, ID_EX_BUBBLE, PIPE_HOLD;
   logic [1:0] FWD_RS1_SEL, FWD_RS2_SEL;
   logic [CNT_W-1:0] STALL_COUNT;

   int n_assert = 0;
   int n_fail   = 0;
   int exp_cnt  = 0;

   always #5 CLK = ~CLK;

   load_use_hazard_unit #(.REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RESET(RESET),
      .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
      .USE_RS1_ID(USE_RS1_ID), .USE_RS2_ID(USE_RS2_ID),
      .DEST_ALU(DEST_ALU), .REG_WRITE_ALU(REG_WRITE_ALU), .MEM_READ_ALU(MEM_READ_ALU),
      .DEST_MEM(DEST_MEM), .REG_WRITE_MEM(REG_WRITE_MEM),
      .MEM_BUSY(MEM_BUSY), .BRANCH_TAKEN(BRANCH_TAKEN),
      .PC_WRITE_EN(PC_WRITE_EN), .IF_ID_WRITE_EN(IF_ID_WRITE_EN),
      .ID_EX_BUBBLE(ID_EX_BUBBLE), .PIPE_HOLD(PIPE_HOLD),
      .FWD_RS1_SEL(FWD_RS1_SEL), .FWD_RS2_SEL(FWD_RS2_SEL)
`ifdef LOAD_USE_PERF_CNT_EN
      , .STALL_COUNT(STALL_COUNT)
`endif
   );

`ifndef LOAD_USE_PERF_CNT_EN
   assign STALL_COUNT = '0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Control bits packed as {PC_WRITE_EN, IF_ID_WRITE_EN, ID_EX_BUBBLE, PIPE_HOLD}.
   task automatic check_ctl(input string tag, input logic [3:0] exp);
      check(tag, {28'd0, PC_WRITE_EN, IF_ID_WRITE_EN, ID_EX_BUBBLE, PIPE_HOLD}, {28'd0, exp});
   endtask

   task automatic check_sel(input string tag, input logic [3:0] exp);
      check(tag, {28'd0, FWD_RS1_SEL, FWD_RS2_SEL}, {28'd0, exp});
   endtask

   task automatic check_state(input string tag, input logic [1:0] exp);
      check(tag, {30'd0, dut.state}, {30'd0, exp});
   endtask

   task automatic check_cnt(input string tag);
`ifdef LOAD_USE_PERF_CNT_EN
      check(tag, {29'd0, STALL_COUNT}, exp_cnt);
`endif
   endtask

   task automatic idle();
      RS1_ID = 5'd0; RS2_ID = 5'd0; USE_RS1_ID = 1'b0; USE_RS2_ID = 1'b0;
      DEST_ALU = 5'd0; REG_WRITE_ALU = 1'b0; MEM_READ_ALU = 1'b0;
      DEST_MEM = 5'd0; REG_WRITE_MEM = 1'b0;
      MEM_BUSY = 1'b0; BRANCH_TAKEN = 1'b0;
   endtask

   task automatic load_x5_use_rs1();
      idle();
      MEM_READ_ALU = 1'b1; REG_WRITE_ALU = 1'b1; DEST_ALU = 5'd5;
      RS1_ID = 5'd5; USE_RS1_ID = 1'b1;
   endtask

   task automatic alu_x8_use_rs1();
      idle();
      REG_WRITE_ALU = 1'b1; DEST_ALU = 5'd8; RS1_ID = 5'd8; USE_RS1_ID = 1'b1;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RESET = 1'b0;
      idle();
      #2;
      check_ctl("reset_ctl", 4'b0010);
      check_sel("reset_sel", 4'b0000);
      check_state("reset_state", ST_RUN);
      check_cnt("reset_cnt");
      @(negedge CLK);
      RESET = 1'b1;
      tick();
      check_ctl("idle_ctl", 4'b1100);

      // Load x5 in EX, ID reads x5 through RS1
      load_x5_use_rs1();
      #1 check_ctl("lu_ctl", 4'b0010);
      tick(); exp_cnt++;
      check_state("lu_state", ST_LOAD_STALL);
      check_sel("lu_sel", 4'b0000);
      check_cnt("lu_cnt");
      idle();
      RS1_ID = 5'd5; USE_RS1_ID = 1'b1; DEST_MEM = 5'd5; REG_WRITE_MEM = 1'b1;
      #1 check_ctl("lu_resume_ctl", 4'b1100);
      tick();
      check_sel("lu_fwd_mem", 4'b1000);
      check_state("lu_back_run", ST_RUN);

      // x7 in both EX and MEM: EX wins
      idle();
      DEST_ALU = 5'd7; REG_WRITE_ALU = 1'b1; DEST_MEM = 5'd7; REG_WRITE_MEM = 1'b1;
      RS2_ID = 5'd7; USE_RS2_ID = 1'b1; RS1_ID = 5'd3; USE_RS1_ID = 1'b1;
      #1 check_ctl("ex_prio_ctl", 4'b1100);
      tick();
      check_sel("ex_prio_sel", 4'b0001);

      // RS1 from EX, RS2 from MEM
      idle();
      DEST_ALU = 5'd4; REG_WRITE_ALU = 1'b1; RS1_ID = 5'd4; USE_RS1_ID = 1'b1;
      DEST_MEM = 5'd9; REG_WRITE_MEM = 1'b1; RS2_ID = 5'd9; USE_RS2_ID = 1'b1;
      tick();
      check_sel("split_sel", 4'b0110);

      // Writes to x0 never stall or forward
      idle();
      MEM_READ_ALU = 1'b1; REG_WRITE_ALU = 1'b1; DEST_ALU = 5'd0;
      DEST_MEM = 5'd0; REG_WRITE_MEM = 1'b1;
      USE_RS1_ID = 1'b1; USE_RS2_ID = 1'b1;
      #1 check_ctl("x0_ctl", 4'b1100);
      tick();
      check_sel("x0_sel", 4'b0000);

      // Load x6 not actually read, then read through RS2
      idle();
      MEM_READ_ALU = 1'b1; REG_WRITE_ALU = 1'b1; DEST_ALU = 5'd6;
      RS1_ID = 5'd6; RS2_ID = 5'd6;
      #1 check_ctl("unused_src_ctl", 4'b1100);
      USE_RS2_ID = 1'b1;
      #1 check_ctl("lu_rs2_ctl", 4'b0010);
      tick(); exp_cnt++;
      check_cnt("lu_rs2_cnt");

      // Memory busy for 3 cycles with a load-use pending
      alu_x8_use_rs1();
      tick();
      check_sel("pre_hold_sel", 4'b0100);
      load_x5_use_rs1();
      MEM_BUSY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         BRANCH_TAKEN = (i == 1);
         #1 check_ctl("hold_ctl", 4'b0001);
         tick();
         check_state("hold_state", ST_MEM_HOLD);
         check_sel("hold_sel", 4'b0100);
         check_cnt("hold_cnt");
      end
      MEM_BUSY = 1'b0; BRANCH_TAKEN = 1'b0;
      #1 check_ctl("post_hold_ctl", 4'b0010);
      tick(); exp_cnt++;
      check_state("post_hold_state", ST_LOAD_STALL);
      check_sel("post_hold_sel", 4'b0000);
      check_cnt("post_hold_cnt");

      // Branch overrides load-use
      alu_x8_use_rs1();
      tick();
      check_sel("pre_br_sel", 4'b0100);
      load_x5_use_rs1();
      DEST_MEM = 5'd5; REG_WRITE_MEM = 1'b1; BRANCH_TAKEN = 1'b1;
      #1 check_ctl("br_ctl", 4'b1110);
      tick();
      check_state("br_state", ST_RUN);
      check_sel("br_sel", 4'b0000);
      check_cnt("br_cnt");

      // Reset in the middle of a load stall
      load_x5_use_rs1();
      tick(); exp_cnt++;
      check_state("pre_rst_state", ST_LOAD_STALL);
      #2 RESET = 1'b0;
      exp_cnt = 0;
      #1 check_ctl("rst_mid_ctl", 4'b0010);
      check_state("rst_mid_state", ST_RUN);
      check_cnt("rst_mid_cnt");
      @(negedge CLK);
      RESET = 1'b1;
      idle();
      #1 check_ctl("rst_rel_ctl", 4'b1100);
      tick();
      check_sel("rst_rel_sel", 4'b0000);
      check_state("rst_rel_state", ST_RUN);
      check_ctl("rst_rel_ctl2", 4'b1100);

`ifdef LOAD_USE_PERF_CNT_EN
      // Back-to-back load-use stalls drive the counter into saturation
      load_x5_use_rs1();
      for (int i = 0; i < 9; i++) begin
         tick();
         if (exp_cnt < (2 ** CNT_W) - 1) exp_cnt++;
         check_cnt("sat_cnt");
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
